jump_issue_arbiter: RTL
=======================

Name: jump_issue_arbiter

Overview:
- Shares the single Jump functional unit between NUM_REQ issue ports.
- Arbitrates round-robin among valid issue requests and holds the winner in a one-entry pipeline register.
- Presents the held request to the Jump unit with a valid/ready handshake.
- Drops held or incoming uops killed by a backend redirect, using robIdx age comparison.

Parameters:
- NUM_REQ, 2, number of issue ports sharing the Jump unit (2..4).
- UOP_W, 180, width of opaque uop payload (src_0, src_1, pc, pd, ftqPtr/offset, fuOpType, imm, pdest, wen bits), passed through unchanged.
- ROB_IDX_W, 5, width of robIdx value field (ROB of 32 entries).

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  NUM_REQ  per-port request valid.
- in_ready  out  NUM_REQ  per-port request accepted this cycle.
- in_uop  in  NUM_REQ*UOP_W  per-port payload; port i at [i*UOP_W +: UOP_W].
- in_rob_flag  in  NUM_REQ  per-port robIdx flag.
- in_rob_value  in  NUM_REQ*ROB_IDX_W  per-port robIdx value.
- redirect_valid  in  1  backend redirect/flush this cycle.
- redirect_rob_flag  in  1  redirect robIdx flag.
- redirect_rob_value  in  ROB_IDX_W  redirect robIdx value.
- redirect_flush_self  in  1  redirect also kills the uop with equal robIdx.
- out_valid  out  1  request to Jump unit.
- out_ready  in  1  Jump unit accepts.
- out_uop  out  UOP_W  held payload.
- out_rob_flag  out  1  held robIdx flag.
- out_rob_value  out  ROB_IDX_W  held robIdx value.
- out_port  out  $clog2(NUM_REQ)  index of the port the held uop came from.

Behaviour:
- Reset (reset==0 at a clock edge):
  - out_valid=0.
  - RR pointer=0.
  - out_uop, out_rob_*, out_port cleared to 0.
  - in_ready=0 while reset is asserted.
- Age rule: isAfter(a,b) = (a.flag != b.flag) ? (a.value < b.value) : (a.value > b.value).
- Kill rule: uop u is killed iff redirect_valid & (isAfter(u,redirect) | (redirect_flush_self & u==redirect)).
- Slot free: can_load = !out_valid | out_ready | kill(held).
- Grant:
  - Among in_valid ports, pick the first valid port at or after the RR pointer (wrapping modulo NUM_REQ).
  - in_ready[g] = can_load & !redirect_valid for the granted port only.
  - All other ports see in_ready=0.
  - A port whose in_valid=0 never sees in_ready=1.
- Load:
  - On in_valid[g] & in_ready[g], the register captures in_uop[g], robIdx[g] and g.
  - out_valid=1 from the next cycle; latency is exactly 1 cycle.
  - RR pointer becomes (g+1) mod NUM_REQ.
  - The pointer does not move when no transfer happens.
- Hold: if out_valid & !out_ready & !kill(held), the register and outputs stay stable. Payload is never changed while out_valid=1 and not yet accepted.
- Drain: out_valid & out_ready with no new load means out_valid=0 next cycle.
- Back-to-back: accept and load in the same cycle gives a new uop every cycle; throughput is 1/cycle.
- Redirect cycle:
  - No input is accepted (in_ready=0 for all ports).
  - A killed held uop is dropped: out_valid=0 next cycle, even if out_ready=0.
  - A non-killed held uop follows normal hold/drain rules.
  - out_valid is not masked combinationally in the redirect cycle; the Jump unit applies its own kill.
- Wrap-around: the age compare must be correct across flag toggles, e.g. held (1,2) vs redirect (0,30) is younger and must be killed.
- Reset mid-operation: a held uop is discarded without handshake.

Decomposition:
- Shared package holds:
  - ROB_IDX_W.
  - robIdx struct {flag, value}.
  - is_after() function.
  - need_flush(u, redirect_valid, redirect_idx, flush_self) function.
  - These are reused by the other backend issue/redirect blocks.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: valid vector, pointer.
  - Outputs: one-hot grant and index.
  - Combinational.
  - The pointer register stays in the parent.

Test Plan:
- Both ports valid for 4 cycles, out_ready=1 → grants alternate port 0,1,0,1; out_port follows 1 cycle later; out_valid stays 1.
- Port 0 loaded at robIdx (0,5), out_ready=0 for 3 cycles → out_uop and out_rob stable; both in_ready stay 0; out_ready=1 then drains; out_valid=0 next cycle if no input.
- Held (0,10), redirect (0,8) flush_self=0 → held killed, out_valid=0 next cycle. Repeat with redirect (0,10) and flush_self=0 → held kept. Same with flush_self=1 → held killed.
- Flag wrap: held (1,2), redirect (0,30) → killed. Held (0,30), redirect (1,2) → kept.
- redirect_valid with port 1 valid and the slot empty → in_ready=0 that cycle; port 1 is accepted the following cycle and the RR pointer then advances.
- reset=0 asserted while out_valid=1 and out_ready=0 → out_valid=0 and pointer=0 after the edge; first grant after release goes to port 0 when both ports are valid.

Source files
------------

// File: rtl/jump_issue_arbiter_pkg.sv
// Shared robIdx definitions for the backend issue/redirect blocks.
//   ROB_IDX_W   : width of the robIdx value field (32-entry ROB)
//   rob_idx_t   : {flag, value} pair; the flag toggles on every ROB wrap
//   is_after()  : true when a is younger than b
//   need_flush(): true when a redirect kills uop u
package jump_issue_arbiter_pkg;

  localparam int ROB_IDX_W = 5;

  typedef struct packed {
    logic                 flag;
    logic [ROB_IDX_W-1:0] value;
  } rob_idx_t;

  // Differing flags mean one index has wrapped, so the value order inverts.
  function automatic logic is_after(rob_idx_t a, rob_idx_t b);
    return (a.flag != b.flag) ? (a.value < b.value) : (a.value > b.value);
  endfunction

  function automatic logic need_flush(rob_idx_t u, logic redirect_valid,
                                      rob_idx_t redirect_idx, logic flush_self);
    return redirect_valid & (is_after(u, redirect_idx) |
                             (flush_self & (u == redirect_idx)));
  endfunction

endpackage

// File: rtl/jump_issue_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first valid request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
//   valid     : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (all zero when nothing is valid)
//   grant_idx : binary index of the granted request
module jump_issue_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/jump_issue_arbiter.sv
// Shares the single Jump unit between NUM_REQ issue ports. A round-robin
// winner is captured into a one-entry register and offered downstream with
// a valid/ready handshake; a held uop younger than a redirect is dropped.
//   clock, reset          : clock, synchronous active-low reset
//   in_valid/in_ready     : per-port issue handshake
//   in_uop, in_rob_*      : per-port payload and robIdx (port i at slice i)
//   redirect_*            : backend redirect and its robIdx / flush-self bit
//   out_valid/out_ready   : handshake toward the Jump unit
//   out_uop, out_rob_*    : held payload and robIdx
//   out_port              : source port of the held uop
module jump_issue_arbiter
  import jump_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int UOP_W   = 180,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             in_valid,
  output logic [NUM_REQ-1:0]             in_ready,
  input  logic [NUM_REQ*UOP_W-1:0]       in_uop,
  input  logic [NUM_REQ-1:0]             in_rob_flag,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   in_rob_value,
  input  logic                           redirect_valid,
  input  logic                           redirect_rob_flag,
  input  logic [ROB_IDX_W-1:0]           redirect_rob_value,
  input  logic                           redirect_flush_self,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [UOP_W-1:0]               out_uop,
  output logic                           out_rob_flag,
  output logic [ROB_IDX_W-1:0]           out_rob_value,
  output logic [PTR_W-1:0]               out_port
);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  rob_idx_t           held_idx;
  rob_idx_t           redirect_idx;
  logic               kill_held;
  logic               can_load;
  logic               fire;

  jump_issue_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid     (in_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign held_idx     = {out_rob_flag, out_rob_value};
  assign redirect_idx = {redirect_rob_flag, redirect_rob_value};
  assign kill_held    = need_flush(held_idx, redirect_valid, redirect_idx,
                                   redirect_flush_self);

  // A killed held uop frees the slot just like a downstream accept.
  assign can_load = !out_valid | out_ready | kill_held;

  // Nothing is accepted during a redirect, so an incoming uop never needs
  // its own kill check; reset also blocks acceptance.
  assign in_ready = (reset & can_load & !redirect_valid) ? grant : '0;
  assign fire     = |(in_valid & in_ready);

  assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_uop       <= '0;
      out_rob_flag  <= 1'b0;
      out_rob_value <= '0;
      out_port      <= '0;
      rr_ptr        <= '0;
    end else if (fire) begin
      out_valid     <= 1'b1;
      out_uop       <= in_uop[grant_idx*UOP_W +: UOP_W];
      out_rob_flag  <= in_rob_flag[grant_idx];
      out_rob_value <= in_rob_value[grant_idx*ROB_IDX_W +: ROB_IDX_W];
      out_port      <= grant_idx;
      rr_ptr        <= next_ptr;
    end else if (out_valid & (out_ready | kill_held)) begin
      out_valid <= 1'b0;
    end
  end

endmodule
